// File: rtl/l2_arbiter_pkg.sv
// Shared types and default widths for the L1-to-L2 miss-port arbiter.
package l2_arbiter_pkg;

    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned LINE_W_DEF = 256;

    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D
    } arb_state_t;

    typedef enum logic {
        GRANT_I,
        GRANT_D
    } grant_t;

endpackage

// File: rtl/l2_arbiter.sv
// Merges the L1 I-cache and D-cache miss ports onto the single L2 request port.
// One side is granted at a time and held until l2_resp; ties alternate round-robin.
module l2_arbiter
    import l2_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned LINE_W = LINE_W_DEF
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_mem_read,
    input  logic [ADDR_W-1:0] i_mem_address,
    output logic [LINE_W-1:0] i_mem_rdata,
    output logic              i_mem_resp,

    input  logic              d_mem_read,
    input  logic              d_mem_write,
    input  logic [ADDR_W-1:0] d_mem_address,
    input  logic [LINE_W-1:0] d_mem_wdata,
    output logic [LINE_W-1:0] d_mem_rdata,
    output logic              d_mem_resp,

    output logic              l2_read,
    output logic              l2_write,
    output logic [ADDR_W-1:0] l2_address,
    output logic [LINE_W-1:0] l2_wdata,
    input  logic [LINE_W-1:0] l2_rdata,
    input  logic              l2_resp
);

    arb_state_t        state;
    grant_t            last_grant;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q;
    logic              read_q;
    logic              write_q;

    logic req_i;
    logic req_d;
    logic pick_d;

    always_comb begin
        req_i  = i_mem_read;
        req_d  = d_mem_read | d_mem_write;
        pick_d = req_d & (~req_i | (last_grant == GRANT_I));
    end

    // The latched request is cleared on completion so every L2-side output
    // is a plain register that reads zero whenever the arbiter is idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= GRANT_D;
            addr_q     <= '0;
            wdata_q    <= '0;
            read_q     <= 1'b0;
            write_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_d) begin
                        state      <= SERVE_D;
                        last_grant <= GRANT_D;
                        addr_q     <= d_mem_address;
                        wdata_q    <= d_mem_wdata;
                        read_q     <= ~d_mem_write;
                        write_q    <= d_mem_write;
                    end else if (req_i) begin
                        state      <= SERVE_I;
                        last_grant <= GRANT_I;
                        addr_q     <= i_mem_address;
                        wdata_q    <= '0;
                        read_q     <= 1'b1;
                        write_q    <= 1'b0;
                    end
                end
                SERVE_I, SERVE_D: begin
                    if (l2_resp) begin
                        state   <= IDLE;
                        addr_q  <= '0;
                        wdata_q <= '0;
                        read_q  <= 1'b0;
                        write_q <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        l2_read     = read_q;
        l2_write    = write_q;
        l2_address  = addr_q;
        l2_wdata    = wdata_q;
        i_mem_resp  = (state == SERVE_I) & l2_resp;
        d_mem_resp  = (state == SERVE_D) & l2_resp;
        i_mem_rdata = (state == SERVE_I) ? l2_rdata : '0;
        d_mem_rdata = (state == SERVE_D) ? l2_rdata : '0;
    end

endmodule
